// File: rtl/sd_crc_engine.sv
// Multi-lane, bit-serial CRC engine for the SD host controller.
// Each lane runs an independent MSB-first CRC (init 0, no reflection, no final XOR).
// After the data phase the engine either shifts the CRC out (generate mode)
// or compares it with received tail bits (check mode).
module sd_crc_engine #(
    parameter int               CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = 16'h1021,
    parameter int               LANES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   mode,
    input  logic                   din_valid,
    input  logic [LANES-1:0]       din,
    input  logic                   din_last,
    output logic [LANES-1:0]       dout,
    output logic                   dout_valid,
    output logic                   busy,
    output logic                   done,
    output logic [LANES*CRC_W-1:0] crc,
    output logic [LANES-1:0]       crc_err
);

    localparam int                 CNT_W    = $clog2(CRC_W + 1);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(CRC_W - 1);

    typedef enum logic [1:0] {IDLE, DATA, TAIL, DONE} state_t;

    state_t                   state;
    state_t                   state_next;
    logic                     mode_q;
    logic [LANES*CRC_W-1:0]   r_q;
    logic [LANES*CRC_W-1:0]   r_upd;
    logic [LANES*CRC_W-1:0]   r_shift;
    logic [LANES-1:0]         r_msb;
    logic [CNT_W-1:0]         tail_cnt;
    logic                     tail_adv;
    logic                     tail_end;

    // One serial CRC step: feedback is the incoming bit XOR the register MSB.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] r, input logic b);
        logic fb;
        fb = b ^ r[CRC_W-1];
        return {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    endfunction

    // Per-lane next values: data update, plain left shift for the tail, and the MSBs.
    always_comb begin
        r_upd   = r_q;
        r_shift = r_q;
        r_msb   = '0;
        for (int i = 0; i < LANES; i++) begin
            r_upd[i*CRC_W +: CRC_W]   = crc_step(r_q[i*CRC_W +: CRC_W], din[i]);
            r_shift[i*CRC_W +: CRC_W] = {r_q[i*CRC_W +: CRC_W-1], 1'b0};
            r_msb[i]                  = r_q[i*CRC_W + CRC_W - 1];
        end
    end

    // Generate mode shifts every TAIL cycle; check mode only on accepted beats.
    assign tail_adv = (state == TAIL) && (!mode_q || din_valid);
    assign tail_end = tail_adv && (tail_cnt == LAST_CNT);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs; start aborts from any state.
    always_comb begin
        state_next = state;
        dout_valid = 1'b0;
        dout       = '0;
        busy       = (state != IDLE);
        done       = (state == DONE);
        if (state == TAIL && !mode_q) begin
            dout_valid = 1'b1;
            dout       = r_msb;
        end
        if (start) begin
            state_next = DATA;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                DATA:    if (din_valid && din_last) state_next = TAIL;
                TAIL:    if (tail_end) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // CRC registers, tail counter, latched mode, result and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q      <= '0;
            crc      <= '0;
            crc_err  <= '0;
            tail_cnt <= '0;
            mode_q   <= 1'b0;
        end else if (start) begin
            r_q      <= '0;
            crc_err  <= '0;
            tail_cnt <= '0;
            mode_q   <= mode;
        end else begin
            case (state)
                DATA: begin
                    if (din_valid) begin
                        r_q <= r_upd;
                        if (din_last) begin
                            crc      <= r_upd;
                            tail_cnt <= '0;
                        end
                    end
                end
                TAIL: begin
                    if (tail_adv) begin
                        r_q      <= r_shift;
                        tail_cnt <= tail_cnt + CNT_W'(1);
                        if (mode_q) begin
                            crc_err <= crc_err | (din ^ r_msb);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_crc_engine.sv
// Directed bench for sd_crc_engine: CRC7 command config, CRC16 single lane,
// and CRC16 four-lane bus config, all sharing one clock and reset.
module tb_sd_crc_engine;

    logic clk;
    logic reset;

    // CRC7, single lane
    logic         start_a, mode_a, valid_a, last_a;
    logic [0:0]   din_a, dout_a, err_a;
    logic         dvld_a, busy_a, done_a;
    logic [6:0]   crc_a;

    // CRC16, single lane
    logic         start_b, mode_b, valid_b, last_b;
    logic [0:0]   din_b, dout_b, err_b;
    logic         dvld_b, busy_b, done_b;
    logic [15:0]  crc_b;

    // CRC16, four lanes
    logic         start_c, mode_c, valid_c, last_c;
    logic [3:0]   din_c, dout_c, err_c;
    logic         dvld_c, busy_c, done_c;
    logic [63:0]  crc_c;

    int checks = 0;
    int errors = 0;

    sd_crc_engine #(.CRC_W(7), .POLY(7'h09), .LANES(1)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .mode(mode_a),
        .din_valid(valid_a), .din(din_a), .din_last(last_a),
        .dout(dout_a), .dout_valid(dvld_a), .busy(busy_a), .done(done_a),
        .crc(crc_a), .crc_err(err_a));

    sd_crc_engine #(.CRC_W(16), .POLY(16'h1021), .LANES(1)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .mode(mode_b),
        .din_valid(valid_b), .din(din_b), .din_last(last_b),
        .dout(dout_b), .dout_valid(dvld_b), .busy(busy_b), .done(done_b),
        .crc(crc_b), .crc_err(err_b));

    sd_crc_engine #(.CRC_W(16), .POLY(16'h1021), .LANES(4)) u_c (
        .clk(clk), .reset(reset), .start(start_c), .mode(mode_c),
        .din_valid(valid_c), .din(din_c), .din_last(last_c),
        .dout(dout_c), .dout_valid(dvld_c), .busy(busy_c), .done(done_c),
        .crc(crc_c), .crc_err(err_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [39:0] CMD0 = 40'h4000000000;
    localparam logic [39:0] CMD8 = 40'h48000001AA;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start7(input logic m);
        start_a = 1'b1;
        mode_a  = m;
        step();
        start_a = 1'b0;
    endtask

    task automatic feed7(input logic [39:0] v);
        for (int i = 39; i >= 0; i--) begin
            valid_a = 1'b1;
            din_a   = v[i];
            last_a  = (i == 0);
            step();
        end
        valid_a = 1'b0;
        last_a  = 1'b0;
        din_a   = 1'b0;
    endtask

    // Drain a generate-mode tail and check serial bits, then the done pulse.
    task automatic drain7(input logic [6:0] exp);
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (dvld_a !== 1'b1 || dout_a !== exp[6-k]) begin
                errors++;
                $display("FAIL drain7 bit%0d: dout_valid=%b dout=%b, required 1/%b", k, dvld_a, dout_a, exp[6-k]);
            end
            step();
        end
        checks++;
        if (done_a !== 1'b1 || dvld_a !== 1'b0 || dout_a !== 1'b0) begin
            errors++;
            $display("FAIL drain7 done: done=%b dout_valid=%b dout=%b, required 1/0/0", done_a, dvld_a, dout_a);
        end
        step();
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL drain7 idle: done=%b busy=%b, required 0/0", done_a, busy_a);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({dout_a, dvld_a, busy_a, done_a, crc_a, err_a} !== '0) begin
            errors++;
            $display("FAIL reset_a: outputs=%h, required 0", {dout_a, dvld_a, busy_a, done_a, crc_a, err_a});
        end
        checks++;
        if ({dout_b, dvld_b, busy_b, done_b, crc_b, err_b} !== '0) begin
            errors++;
            $display("FAIL reset_b: outputs=%h, required 0", {dout_b, dvld_b, busy_b, done_b, crc_b, err_b});
        end
        checks++;
        if ({dout_c, dvld_c, busy_c, done_c, crc_c, err_c} !== '0) begin
            errors++;
            $display("FAIL reset_c: outputs=%h, required 0", {dout_c, dvld_c, busy_c, done_c, crc_c, err_c});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_cmd0_generate();
        start7(1'b0);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL cmd0 busy: busy=%b, required 1", busy_a);
        end
        feed7(CMD0);
        checks++;
        if (crc_a !== 7'h4A) begin
            errors++;
            $display("FAIL cmd0 crc: crc=%h, required 4a", crc_a);
        end
        drain7(7'h4A);
    endtask

    task automatic test_cmd8_check();
        logic [6:0] tail;
        tail = 7'b1000011;
        start7(1'b1);
        feed7(CMD8);
        checks++;
        if (crc_a !== 7'h43 || dvld_a !== 1'b0) begin
            errors++;
            $display("FAIL cmd8 crc: crc=%h dout_valid=%b, required 43/0", crc_a, dvld_a);
        end
        for (int k = 0; k < 7; k++) begin
            valid_a = 1'b1;
            din_a   = tail[6-k];
            step();
        end
        valid_a = 1'b0;
        checks++;
        if (done_a !== 1'b1 || err_a !== 1'b0 || crc_a !== 7'h43) begin
            errors++;
            $display("FAIL cmd8 check: done=%b crc_err=%b crc=%h, required 1/0/43", done_a, err_a, crc_a);
        end
        step();
    endtask

    task automatic crc16_run(input logic [15:0] tail, input logic exp_err);
        start_b = 1'b1;
        mode_b  = 1'b1;
        step();
        start_b = 1'b0;
        checks++;
        if (err_b !== 1'b0) begin
            errors++;
            $display("FAIL crc16 err_clear: crc_err=%b, required 0", err_b);
        end
        for (int k = 0; k < 4096; k++) begin
            valid_b = 1'b1;
            din_b   = 1'b1;
            last_b  = (k == 4095);
            step();
        end
        last_b = 1'b0;
        checks++;
        if (crc_b !== 16'h7FA1) begin
            errors++;
            $display("FAIL crc16 crc: crc=%h, required 7fa1", crc_b);
        end
        for (int k = 0; k < 16; k++) begin
            din_b = tail[15-k];
            step();
        end
        valid_b = 1'b0;
        checks++;
        if (done_b !== 1'b1 || err_b !== exp_err) begin
            errors++;
            $display("FAIL crc16 check tail=%h: done=%b crc_err=%b, required 1/%b", tail, done_b, err_b, exp_err);
        end
        step();
    endtask

    task automatic test_crc16_check();
        crc16_run(16'h7FA0, 1'b1);
        crc16_run(16'h7FA1, 1'b0);
    endtask

    task automatic test_lanes4_check();
        logic [71:0] msg;
        logic [15:0] t0, t1, t2, t3;
        logic        early_done;
        int          idx;
        msg = 72'h313233343536373839;
        t0  = 16'h7FA1;
        t1  = 16'h0000;
        t2  = 16'h31C3 ^ 16'h0100;
        t3  = 16'h1021;
        early_done = 1'b0;
        start_c = 1'b1;
        mode_c  = 1'b1;
        step();
        start_c = 1'b0;
        for (int k = 0; k < 4096; k++) begin
            idx     = 4095 - k;
            valid_c = 1'b1;
            din_c   = {(k == 4095), (idx < 72) ? msg[idx] : 1'b0, 1'b0, 1'b1};
            last_c  = (k == 4095);
            step();
        end
        checks++;
        if (crc_c !== {16'h1021, 16'h31C3, 16'h0000, 16'h7FA1}) begin
            errors++;
            $display("FAIL lanes4 crc: crc=%h, required 1021_31c3_0000_7fa1", crc_c);
        end
        for (int j = 0; j < 16; j++) begin
            if (j % 2 == 1) begin
                valid_c = 1'b0;
                din_c   = ~{t3[15-j], t2[15-j], t1[15-j], t0[15-j]};
                step();
                step();
                if (done_c !== 1'b0) early_done = 1'b1;
            end
            valid_c = 1'b1;
            last_c  = 1'b1;
            din_c   = {t3[15-j], t2[15-j], t1[15-j], t0[15-j]};
            step();
            if (j < 15 && done_c !== 1'b0) early_done = 1'b1;
        end
        valid_c = 1'b0;
        last_c  = 1'b0;
        checks++;
        if (early_done !== 1'b0) begin
            errors++;
            $display("FAIL lanes4 stall: early done=%b, required 0", early_done);
        end
        checks++;
        if (done_c !== 1'b1 || err_c !== 4'b0100) begin
            errors++;
            $display("FAIL lanes4 check: done=%b crc_err=%b, required 1/0100", done_c, err_c);
        end
        step();
        checks++;
        if (busy_c !== 1'b0 || err_c !== 4'b0100) begin
            errors++;
            $display("FAIL lanes4 hold: busy=%b crc_err=%b, required 0/0100", busy_c, err_c);
        end
    endtask

    task automatic test_abort();
        logic saw_done;
        saw_done = 1'b0;
        start7(1'b0);
        for (int i = 39; i >= 20; i--) begin
            valid_a = 1'b1;
            din_a   = CMD8[i];
            step();
            if (done_a !== 1'b0) saw_done = 1'b1;
        end
        start_a = 1'b1;
        mode_a  = 1'b0;
        valid_a = 1'b1;
        din_a   = 1'b1;
        step();
        start_a = 1'b0;
        valid_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1 || crc_a !== 7'h43) begin
            errors++;
            $display("FAIL abort restart: busy=%b crc=%h, required 1/43", busy_a, crc_a);
        end
        for (int i = 39; i >= 1; i--) begin
            valid_a = 1'b1;
            din_a   = CMD0[i];
            step();
            if (done_a !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (crc_a !== 7'h43 || saw_done !== 1'b0) begin
            errors++;
            $display("FAIL abort hold: crc=%h saw_done=%b, required 43/0", crc_a, saw_done);
        end
        din_a  = CMD0[0];
        last_a = 1'b1;
        step();
        valid_a = 1'b0;
        last_a  = 1'b0;
        checks++;
        if (crc_a !== 7'h4A) begin
            errors++;
            $display("FAIL abort crc: crc=%h, required 4a", crc_a);
        end
        drain7(7'h4A);
    endtask

    task automatic test_reset_in_tail();
        start7(1'b0);
        feed7(CMD8);
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({dout_a, dvld_a, busy_a, done_a, crc_a, err_a} !== '0) begin
            errors++;
            $display("FAIL tail_reset: outputs=%h, required 0", {dout_a, dvld_a, busy_a, done_a, crc_a, err_a});
        end
        reset = 1'b0;
        step();
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL tail_reset idle: busy=%b done=%b, required 0/0", busy_a, done_a);
        end
        start7(1'b0);
        feed7(CMD0);
        checks++;
        if (crc_a !== 7'h4A) begin
            errors++;
            $display("FAIL tail_reset rerun crc: crc=%h, required 4a", crc_a);
        end
        drain7(7'h4A);
    endtask

    initial begin
        reset   = 1'b1;
        start_a = 1'b0; mode_a = 1'b0; valid_a = 1'b0; last_a = 1'b0; din_a = '0;
        start_b = 1'b0; mode_b = 1'b0; valid_b = 1'b0; last_b = 1'b0; din_b = '0;
        start_c = 1'b0; mode_c = 1'b0; valid_c = 1'b0; last_c = 1'b0; din_c = '0;
        test_reset();
        test_cmd0_generate();
        test_cmd8_check();
        test_crc16_check();
        test_lanes4_check();
        test_abort();
        test_reset_in_tail();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_crc_engine.md
# sd_crc_engine

Parametrised, multi-lane, bit-serial CRC engine for the SD host controller. One instance covers the 40-bit command CRC7 (CRC_W=7, POLY=7'h09, LANES=1) and the 4-bit-wide data-bus CRC16 (CRC_W=16, POLY=16'h1021, LANES=4). Data is streamed in as one bit per lane per accepted beat; blocks of any length are supported. After the last data bit the engine does one of two things, selected per block:
- Generate mode: serialises the CRC out MSB first, for transmit.
- Check mode: consumes the received CRC bits and flags mismatches per lane, for receive.

## Interface
Parameters:
- CRC_W, 16, CRC register width in bits (2..32)
- POLY, 16'h1021, generator polynomial with the implicit x^CRC_W term omitted
- LANES, 4, number of independent parallel lanes (1..8)

Ports:
- clk  in  1  clock, all state changes on the rising edge
- reset  in  1  asynchronous, active-high; clock clk
- start  in  1  one-cycle pulse; clears all CRC registers, latches mode, enters DATA
- mode  in  1  sampled only on start: 0 = generate, 1 = check
- din_valid  in  1  din carries one bit per lane this cycle
- din  in  LANES  serial input bit for each lane (lane i = din[i])
- din_last  in  1  qualifies the final data beat; meaningful only with din_valid in DATA
- dout  out  LANES  generate mode: CRC bit per lane, MSB first
- dout_valid  out  1  dout is valid this cycle
- busy  out  1  state is not IDLE
- done  out  1  one-cycle completion pulse
- crc  out  LANES*CRC_W  final CRC per lane (lane i at [i*CRC_W +: CRC_W])
- crc_err  out  LANES  check mode: per-lane mismatch flag

## Operation
- States are IDLE, DATA, TAIL, DONE.
- Per-lane update on each accepted data bit:
  - fb = din[i] ^ r[i][CRC_W-1]
  - r[i] <= {r[i][CRC_W-2:0],1'b0} ^ (fb ? POLY : 0)
  - r[i] starts at 0. No reflection and no final XOR.
- IDLE -> DATA on start.
- DATA:
  - Each cycle with din_valid updates all lanes.
  - If din_last is also set, that bit is included, crc is loaded with the updated r values, tail_cnt is cleared, and the state goes to TAIL.
- TAIL, generate mode:
  - dout[i] = r[i][CRC_W-1] and dout_valid = 1 on every TAIL cycle.
  - r shifts left by 1 each cycle with no stall.
  - After exactly CRC_W cycles the state goes to DONE.
- TAIL, check mode:
  - Advances only on din_valid.
  - On each beat, if din[i] != r[i][CRC_W-1] then crc_err[i] is set (sticky); r then shifts left.
  - After CRC_W accepted beats the state goes to DONE.
  - din_last is ignored in TAIL.
- DONE: done = 1 for one cycle, then IDLE.
- crc and crc_err hold their values until the next start or reset.
- start in any state, including mid-block, aborts the current operation:
  - r, crc_err and tail_cnt are cleared, mode is relatched, and the state goes to DATA.
  - din_valid in that same cycle is ignored.
  - crc keeps its previous value until the new block reaches TAIL.
- din_valid is ignored in IDLE and DONE. din_last without din_valid is ignored.
- A zero-length block is not supported; at least one data beat is required before din_last.
- tail_cnt width is $clog2(CRC_W+1).

## Timing
- Reset values: every output is 0 (dout, dout_valid, busy, done, crc, crc_err). Internally, state = IDLE and r = 0.
- busy rises the cycle after start and falls the cycle after done.
- Generate-mode latency:
  - The first dout_valid is the cycle after the edge that accepted din_last.
  - CRC_W consecutive dout_valid cycles follow, then done on the next cycle.
- Check mode: done is asserted the cycle after the edge accepting the CRC_W-th tail beat. crc_err is valid on that same cycle.
- dout is driven combinationally from r. dout is 0 whenever dout_valid = 0.
- If reset is asserted mid-block, all state clears immediately (asynchronously). No done is produced.

## Test plan
- CMD0, with CRC_W=7, POLY=7'h09, LANES=1, generate mode: stream 40 bits of 40'h4000000000 MSB first with din_last on bit 40 -> crc=7'h4A; dout over 7 cycles = 1,0,0,1,0,1,0; then one done pulse.
- CMD8, same config: stream 40'h48000001AA -> crc=7'h43; check mode with received tail bits 1000011 -> crc_err=0.
- CRC16 with LANES=1: 4096 data bits all 1 -> crc=16'h7FA1. Check mode with tail 16'h7FA1 -> crc_err=0; with tail 16'h7FA0 -> crc_err=1.
- LANES=4, check mode: lanes fed different patterns, and lane 2's tail has one flipped bit -> crc_err=4'b0100. In check TAIL, gaps in din_valid stall the count; done appears only after 16 accepted beats.
- Abort: start asserted mid-DATA with din_valid=1 on the same cycle -> the new block's CRC equals that of a fresh run; no done from the aborted block; crc keeps its previous value until the new TAIL.
- Reset asserted during TAIL -> all outputs are 0 immediately, state is IDLE, and the next start behaves normally.
